// File: rtl/pwm_multi_axil.sv
// ---------------------------------------------------------------------------
// pwm_multi_axil
//   NUM_CH independent PWM channels behind an AXI4-Lite register slave.
//   Each channel has shadow PERIOD/DUTY registers that are copied into the
//   running (active) copies only at the end of a period, so an update never
//   produces a truncated or glitched pulse. Every period end sets a sticky
//   STATUS bit (write-1-to-clear); irq is the OR of STATUS & IRQ_EN.
//
//   Register map (word addressed, addr[1:0] ignored):
//     0x00 CTRL      bit k enables channel k
//     0x04 IRQ_EN    bit k enables channel-k interrupt
//     0x08 STATUS    bit k sticky wrap flag, W1C
//     0x0C ID        {8'h00, NUM_CH, CNT_W, 8'hA1}, read-only
//     0x10+8k        PERIOD_k (CNT_W bits)
//     0x14+8k        DUTY_k   (CNT_W bits)
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*     : AXI4-Lite write address / data / response
//   s_axi_ar*/r*        : AXI4-Lite read address / data
//   pwm_out[NUM_CH]     : registered PWM outputs
//   irq                 : level interrupt, |(STATUS & IRQ_EN)
//
// Parameters
//   NUM_CH 1..16, CNT_W 1..32, ADDR_W with 2^ADDR_W >= 0x10 + 8*NUM_CH
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pwm_multi_axil_ch
//   One PWM channel: counter plus active period/duty copies.
//   i_en is the current CTRL bit, i_en_nxt the value CTRL takes at this edge.
//   Looking at the next value lets the channel start with cnt=0 and a valid
//   output in the very first cycle after the enable write.
// Ports
//   i_per, i_duty : shadow PERIOD/DUTY from the register file
//   o_pwm         : registered PWM output
//   o_wrap        : high in the cycle where cnt == act_per while running
// ---------------------------------------------------------------------------
module pwm_multi_axil_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_en_nxt,
    input  logic [CNT_W-1:0] i_per,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_per;
    logic [CNT_W-1:0] r_act_duty;
    logic             r_pwm;

    logic             w_at_end;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_at_end  = (r_cnt == r_act_per);
    // cnt never exceeds act_per while running, so the increment cannot wrap
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_wrap    = i_en & i_en_nxt & w_at_end;
    assign o_pwm     = r_pwm;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt      <= '0;
            r_act_per  <= '0;
            r_act_duty <= '0;
            r_pwm      <= 1'b0;
        end else if (!i_en_nxt) begin
            // idle: hold at 0 and keep the active copies in step with shadow
            r_cnt      <= '0;
            r_act_per  <= i_per;
            r_act_duty <= i_duty;
            r_pwm      <= 1'b0;
        end else if (!i_en || w_at_end) begin
            // start of a period, either freshly enabled or wrapping
            r_cnt      <= '0;
            r_act_per  <= i_per;
            r_act_duty <= i_duty;
            r_pwm      <= (i_duty != '0);
        end else begin
            r_cnt      <= w_cnt_inc;
            r_pwm      <= (w_cnt_inc < r_act_duty);
        end
    end

endmodule

module pwm_multi_axil #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 6
) (
    input  logic                clock,
    input  logic                reset,
    // write address
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    // write data
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    // write response
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    // read address
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    // read data
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    // PWM / interrupt
    output logic [NUM_CH-1:0]   pwm_out,
    output logic                irq
);

    localparam int          IDX_W  = ADDR_W - 2;
    localparam logic [31:0] ID_VAL = {8'h00, 8'(NUM_CH), 8'(CNT_W), 8'hA1};

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_IRQ_EN = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(3);

    // register file
    logic [NUM_CH-1:0]             r_ctrl;
    logic [NUM_CH-1:0]             r_irq_en;
    logic [NUM_CH-1:0]             r_status;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_per;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_duty;

    // AXI response state
    logic                          r_bvalid;
    logic                          r_rvalid;
    logic [31:0]                   r_rdata;

    logic                          w_wr_acc;
    logic                          w_rd_acc;
    logic [IDX_W-1:0]              w_widx;
    logic [IDX_W-1:0]              w_ridx;
    logic [31:0]                   w_bmask;
    logic [NUM_CH-1:0]             w_ctrl_nxt;
    logic [NUM_CH-1:0]             w_st_clr;
    logic [NUM_CH-1:0]             w_wrap;
    logic [31:0]                   w_rdata;
    logic                          w_unused;

    // byte-lane merge of write data into an existing 32-bit view
    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [31:0] m);
        return (old & ~m) | (wd & m);
    endfunction

    // -----------------------------------------------------------------------
    // handshakes: one write in flight at a time, gated until B is taken
    // -----------------------------------------------------------------------
    assign w_wr_acc      = !reset && s_axi_awvalid && s_axi_wvalid && !r_bvalid;
    assign w_rd_acc      = !reset && s_axi_arvalid && !r_rvalid;

    assign s_axi_awready = w_wr_acc;
    assign s_axi_wready  = w_wr_acc;
    assign s_axi_arready = w_rd_acc;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    assign w_widx  = s_axi_awaddr[ADDR_W-1:2];
    assign w_ridx  = s_axi_araddr[ADDR_W-1:2];
    assign w_bmask = {{8{s_axi_wstrb[3]}}, {8{s_axi_wstrb[2]}},
                      {8{s_axi_wstrb[1]}}, {8{s_axi_wstrb[0]}}};

    // address LSBs are ignored by design
    assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // CTRL value after this edge; channels use it to start cleanly
    assign w_ctrl_nxt = (w_wr_acc && w_widx == IDX_CTRL)
                      ? NUM_CH'(f_merge(32'(r_ctrl), s_axi_wdata, w_bmask))
                      : r_ctrl;

    assign w_st_clr   = (w_wr_acc && w_widx == IDX_STATUS)
                      ? NUM_CH'(s_axi_wdata & w_bmask)
                      : '0;

    assign irq = |(r_status & r_irq_en);

    // -----------------------------------------------------------------------
    // register writes
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctrl   <= '0;
            r_irq_en <= '0;
            r_status <= '0;
            r_per    <= '0;
            r_duty   <= '0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            if (w_wr_acc && w_widx == IDX_IRQ_EN)
                r_irq_en <= NUM_CH'(f_merge(32'(r_irq_en), s_axi_wdata, w_bmask));
            // a wrap in the same cycle as a clear keeps the bit set
            r_status <= (r_status & ~w_st_clr) | w_wrap;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_wr_acc && w_widx == IDX_W'(4 + 2*k))
                    r_per[k]  <= CNT_W'(f_merge(32'(r_per[k]), s_axi_wdata, w_bmask));
                if (w_wr_acc && w_widx == IDX_W'(5 + 2*k))
                    r_duty[k] <= CNT_W'(f_merge(32'(r_duty[k]), s_axi_wdata, w_bmask));
            end
        end
    end

    // -----------------------------------------------------------------------
    // read mux (pre-write register values, so a same-cycle write is unseen)
    // -----------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        case (w_ridx)
            IDX_CTRL:   w_rdata = 32'(r_ctrl);
            IDX_IRQ_EN: w_rdata = 32'(r_irq_en);
            IDX_STATUS: w_rdata = 32'(r_status);
            IDX_ID:     w_rdata = ID_VAL;
            default:    w_rdata = '0;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ridx == IDX_W'(4 + 2*k)) w_rdata = 32'(r_per[k]);
            if (w_ridx == IDX_W'(5 + 2*k)) w_rdata = 32'(r_duty[k]);
        end
    end

    // -----------------------------------------------------------------------
    // AXI response channels
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_wr_acc)
                r_bvalid <= 1'b1;
            else if (s_axi_bready)
                r_bvalid <= 1'b0;

            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // channels
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_multi_axil_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clock    (clock),
            .reset    (reset),
            .i_en     (r_ctrl[k]),
            .i_en_nxt (w_ctrl_nxt[k]),
            .i_per    (r_per[k]),
            .i_duty   (r_duty[k]),
            .o_pwm    (pwm_out[k]),
            .o_wrap   (w_wrap[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_axil.sv
module tb_pwm_multi_axil;

    logic        clock;
    logic        reset;
    logic [5:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [5:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  pwm_out;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;

    pwm_multi_axil #(.NUM_CH(4), .CNT_W(16), .ADDR_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .pwm_out       (pwm_out),
        .irq           (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // called at a negedge; returns two negedges later
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        #1;
        n = 0;
        while (!s_axi_awready && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk("awready", 32'(s_axi_awready & s_axi_wready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clock); n++;
        end
        chk("bvalid", 32'(s_axi_bvalid), 32'd1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk("arready", 32'(s_axi_arready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            @(negedge clock); n++;
        end
        chk("rvalid", 32'(s_axi_rvalid), 32'd1);
        d = s_axi_rdata;
        @(posedge clock);
        @(negedge clock);
    endtask

    // leaves the bench at the negedge where pwm_out[ch] has just risen (cnt=0)
    task automatic wait_rise(input int ch, input string tag);
        logic prev;
        logic got;
        int   n;
        got  = 1'b0;
        n    = 0;
        prev = pwm_out[ch];
        while (!got && n < 40) begin
            @(negedge clock);
            if (!prev && pwm_out[ch]) got = 1'b1;
            prev = pwm_out[ch];
            n++;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    // sample len consecutive cycles, first sample at the current negedge
    task automatic capture(input int ch, input int len, output logic [31:0] v);
        v = '0;
        for (int j = 0; j < len; j++) begin
            v[j] = pwm_out[ch];
            if (j < len - 1) @(negedge clock);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] cap;
        logic        or1;
        logic        and2;
        int          n;

        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0;
        s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;  s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        @(negedge clock);
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1;
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_pwm",     32'(pwm_out), 32'd0);
        chk("rst_irq",     32'(irq), 32'd0);
        chk("rst_bvalid",  32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid",  32'(s_axi_rvalid), 32'd0);
        chk("rst_rdata",   s_axi_rdata, 32'd0);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // ---------------- readback ----------------
        axi_read(6'h0C, rd); chk("id", rd, 32'h000410A1);
        axi_read(6'h00, rd); chk("ctrl_rst", rd, 32'd0);
        for (int i = 0; i < 8; i++) axi_write(6'(16 + 4*i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 8; i++) begin
            axi_read(6'(16 + 4*i), rd);
            chk("shadow_rb", rd, 32'(i + 1));
        end
        axi_read(6'h3C, rd); chk("unmapped", rd, 32'd0);

        // ---------------- interrupt + basic PWM on ch0 ----------------
        axi_write(6'h04, 32'h1, 4'hF);
        axi_write(6'h10, 32'd9, 4'hF);
        axi_write(6'h14, 32'd3, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);          // returns with cnt=1
        chk("irq_pre", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 30) begin @(negedge clock); n++; end
        chk("irq_lat", 32'(n), 32'd9);          // cnt 1 -> wrap -> cnt 0

        wait_rise(0, "rise_a");
        capture(0, 20, cap);                     // cnt 0..9, 0..9
        chk("pwm_3of10", cap, 32'h0001C07);
        chk("others_low", 32'(pwm_out[3:1]), 32'd0);
        axi_write(6'h08, 32'h1, 4'hF);          // accepted on the wrap edge
        chk("set_wins", 32'(irq), 32'd1);
        axi_write(6'h08, 32'h1, 4'hF);          // mid-period clear
        chk("irq_midclr", 32'(irq), 32'd0);
        axi_read(6'h08, rd); chk("status_clr", rd & 32'h1, 32'd0);

        // ---------------- shadow update ----------------
        wait_rise(0, "rise_b");
        repeat (5) @(negedge clock);            // cnt=5
        axi_write(6'h14, 32'd6, 4'hF);          // returns with cnt=7
        chk("tail_low", 32'(pwm_out[0]), 32'd0);
        wait_rise(0, "rise_c");
        capture(0, 20, cap);
        chk("pwm_6of10", cap, 32'h000FC3F);
        wait_rise(0, "rise_d");
        @(negedge clock);                        // cnt=1
        axi_write(6'h14, 32'd3, 4'hF);          // returns with cnt=3
        capture(0, 3, cap);                      // old duty 6 still active
        chk("keep_old", cap, 32'h7);
        wait_rise(0, "rise_e");
        capture(0, 10, cap);
        chk("new_duty3", cap, 32'h007);

        // ---------------- extremes ----------------
        axi_write(6'h18, 32'd9, 4'hF);
        axi_write(6'h1C, 32'd0, 4'hF);
        axi_write(6'h20, 32'd9, 4'hF);
        axi_write(6'h24, 32'd20, 4'hF);
        axi_write(6'h00, 32'h7, 4'hF);          // ch1/ch2 start, cnt=1
        or1  = 1'b0;
        and2 = 1'b1;
        for (int j = 0; j < 24; j++) begin
            @(negedge clock);
            or1  = or1  | pwm_out[1];
            and2 = and2 & pwm_out[2];
        end                                      // ch2 cnt=5
        chk("duty0_low",  32'(or1),  32'd0);
        chk("duty20_high", 32'(and2), 32'd1);
        axi_write(6'h04, 32'h4, 4'hF);          // cnt=7
        axi_write(6'h08, 32'h4, 4'hF);          // cnt=9
        chk("st2_clr", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 30) begin @(negedge clock); n++; end
        chk("st2_lat1", 32'(n), 32'd1);
        axi_write(6'h08, 32'h4, 4'hF);          // cleared at cnt=0 edge, cnt=2
        chk("st2_clr2", 32'(irq), 32'd0);
        n = 0;
        while (!irq && n < 30) begin @(negedge clock); n++; end
        chk("st2_lat2", 32'(n), 32'd8);
        axi_read(6'h08, rd); chk("st2_bit", rd & 32'h4, 32'h4);

        // ---------------- B backpressure ----------------
        s_axi_bready  = 1'b0;
        s_axi_awaddr  = 6'h28; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
        #1;
        chk("bp_acc1", 32'(s_axi_awready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_axi_wdata = 32'h66;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_bvalid", 32'(s_axi_bvalid), 32'd1);
            chk("bp_stall",  32'(s_axi_awready), 32'd0);
            @(negedge clock);
        end
        axi_read(6'h28, rd); chk("bp_first", rd, 32'h55);
        s_axi_bready = 1'b1;
        #1;
        chk("bp_stall2", 32'(s_axi_awready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("bp_acc2", 32'(s_axi_awready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("bp_bvalid2", 32'(s_axi_bvalid), 32'd1);
        @(posedge clock);
        @(negedge clock);
        axi_read(6'h28, rd); chk("bp_second", rd, 32'h66);

        // ---------------- strobes / width / read-only ----------------
        axi_write(6'h10, 32'h0, 4'hF);
        axi_write(6'h10, 32'hFFFF_FFFF, 4'b0001);
        axi_read(6'h10, rd); chk("strb_b0", rd, 32'h0000_00FF);
        axi_write(6'h14, 32'h0, 4'hF);
        axi_write(6'h14, 32'h1234_5678, 4'b0110);
        axi_read(6'h14, rd); chk("strb_mid", rd, 32'h0000_5600);
        axi_write(6'h00, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h00, rd); chk("ctrl_width", rd, 32'h0000_000F);
        axi_write(6'h0C, 32'h0, 4'hF);
        axi_read(6'h0C, rd); chk("id_ro", rd, 32'h000410A1);

        // ---------------- reset mid-transaction ----------------
        chk("pre_rst_pwm2", 32'(pwm_out[2]), 32'd1);
        s_axi_rready  = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr  = 6'h0C; s_axi_arvalid = 1'b1;
        s_axi_awaddr  = 6'h04; s_axi_wdata = 32'hF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("pend_r", 32'(s_axi_rvalid), 32'd1);
        chk("pend_b", 32'(s_axi_bvalid), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mrst_pwm",   32'(pwm_out), 32'd0);
        chk("mrst_irq",   32'(irq), 32'd0);
        chk("mrst_rvld",  32'(s_axi_rvalid), 32'd0);
        chk("mrst_bvld",  32'(s_axi_bvalid), 32'd0);
        chk("mrst_rdata", s_axi_rdata, 32'd0);
        reset = 1'b0;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        @(negedge clock);
        axi_read(6'h00, rd); chk("mrst_ctrl",  rd, 32'd0);
        axi_read(6'h04, rd); chk("mrst_irqen", rd, 32'd0);
        axi_read(6'h08, rd); chk("mrst_stat",  rd, 32'd0);
        axi_read(6'h10, rd); chk("mrst_per0",  rd, 32'd0);
        axi_read(6'h24, rd); chk("mrst_duty2", rd, 32'd0);
        chk("mrst_pwm2", 32'(pwm_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
